// File: rtl/ccr_cond_eval.sv
// ccr_cond_eval: evaluates a 68k-style condition code (Bcc/Scc/DBcc) against
// the CCR across T3/T4/T1 microcycle phases and produces the branch, Scc and
// DBcc loop-counter results.
module ccr_cond_eval (
   input  logic        clk,
   input  logic        pwrUp,
   input  logic        enT1,
   input  logic        enT3,
   input  logic        enT4,
   input  logic        start,
   input  logic [15:0] ird,
   input  logic [4:0]  ccr,
   input  logic [15:0] dbCount,
   output logic        busy,
   output logic        done,
   output logic        condTrue,
   output logic        takeBranch,
   output logic [7:0]  sccByte,
   output logic [15:0] newCount,
   output logic        cntWr
);

   localparam int unsigned CC_W    = 4;
   localparam int unsigned FLAG_W  = 4;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned BYTE_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPT,
      S_EVAL,
      S_DEC,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      CL_NONE,
      CL_BCC,
      CL_DBCC,
      CL_SCC
   } op_class_t;

   state_t              state;
   op_class_t           class_q;
   logic [CC_W-1:0]     cc_q;
   logic [FLAG_W-1:0]   flags_q;   // {N,Z,V,C}
   logic                cond_c;

   // X flag and the register-number bits of ird never influence a result
   logic unused_inputs;
   assign unused_inputs = ^{ird[2:0], ccr[4]};

   // Instruction class from the opcode line, size field and EA mode field
   function automatic op_class_t decode_class(input logic [15:0] ir);
      op_class_t cl;
      cl = CL_NONE;
      if (ir[15:12] == 4'h6)
         cl = CL_BCC;
      else if (ir[15:12] == 4'h5 && ir[7:6] == 2'b11)
         cl = (ir[5:3] == 3'b001) ? CL_DBCC : CL_SCC;
      return cl;
   endfunction

   // Condition truth table; BSR (cc=1) is unconditional for the Bcc class
   function automatic logic eval_cc(input logic [CC_W-1:0] cc,
                                    input logic [FLAG_W-1:0] f,
                                    input op_class_t cl);
      logic n, z, v, c, r;
      n = f[3];
      z = f[2];
      v = f[1];
      c = f[0];
      case (cc)
         4'd0:    r = 1'b1;
         4'd1:    r = (cl == CL_BCC);
         4'd2:    r = ~c & ~z;
         4'd3:    r = c | z;
         4'd4:    r = ~c;
         4'd5:    r = c;
         4'd6:    r = ~z;
         4'd7:    r = z;
         4'd8:    r = ~v;
         4'd9:    r = v;
         4'd10:   r = ~n;
         4'd11:   r = n;
         4'd12:   r = ~(n ^ v);
         4'd13:   r = n ^ v;
         4'd14:   r = ~z & ~(n ^ v);
         default: r = z | (n ^ v);
      endcase
      return r;
   endfunction

   // Condition from the captured opcode and flags
   always_comb begin
      cond_c = eval_cc(cc_q, flags_q, class_q);
   end

   // Sequencer: capture on T3, evaluate on T4, act on T1, decrement on T3,
   // and report completion on the next phase enable
   always_ff @(posedge clk or posedge pwrUp) begin
      if (pwrUp) begin
         state      <= S_IDLE;
         class_q    <= CL_NONE;
         cc_q       <= '0;
         flags_q    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         condTrue   <= 1'b0;
         takeBranch <= 1'b0;
         sccByte    <= '0;
         newCount   <= '0;
         cntWr      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enT3 && start) begin
                  class_q    <= decode_class(ird);
                  cc_q       <= ird[11:8];
                  flags_q    <= ccr[3:0];
                  newCount   <= dbCount;
                  busy       <= 1'b1;
                  condTrue   <= 1'b0;
                  takeBranch <= 1'b0;
                  sccByte    <= '0;
                  cntWr      <= 1'b0;
                  state      <= S_CAPT;
               end
            end
            S_CAPT: begin
               if (enT4) begin
                  condTrue <= cond_c;
                  state    <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (enT1) begin
                  state <= S_DONE;
                  case (class_q)
                     CL_BCC: takeBranch <= condTrue;
                     CL_SCC: sccByte <= condTrue ? {BYTE_W{1'b1}} : BYTE_W'(0);
                     CL_DBCC: begin
                        if (condTrue) begin
                           takeBranch <= 1'b0;
                           cntWr      <= 1'b0;
                        end else begin
                           state <= S_DEC;
                        end
                     end
                     default: begin
                        takeBranch <= 1'b0;
                        sccByte    <= '0;
                     end
                  endcase
               end
            end
            S_DEC: begin
               // Loop continues unless the counter wraps to -1
               if (enT3) begin
                  newCount   <= newCount - CNT_W'(1);
                  cntWr      <= 1'b1;
                  takeBranch <= (newCount != CNT_W'(0));
                  state      <= S_DONE;
               end
            end
            S_DONE: begin
               if (enT1 || enT3 || enT4) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccr_cond_eval.sv
// tb_ccr_cond_eval: directed and randomized checks of ccr_cond_eval against a
// behavioural model of the condition/branch/loop rules.
module tb_ccr_cond_eval;

   logic        clk = 1'b0;
   logic        pwrUp;
   logic        enT1, enT3, enT4, start;
   logic [15:0] ird;
   logic [4:0]  ccr;
   logic [15:0] dbCount;
   logic        busy, done, condTrue, takeBranch, cntWr;
   logic [7:0]  sccByte;
   logic [15:0] newCount;

   int total = 0;
   int bad   = 0;
   int ph    = 0;   // 0:T1 1:T2(no enable) 2:T3 3:T4

   typedef struct {
      logic        ct;
      logic        tb;
      logic [7:0]  scc;
      logic [15:0] nc;
      logic        wr;
      int          lat;
   } exp_t;

   ccr_cond_eval dut (
      .clk(clk), .pwrUp(pwrUp), .enT1(enT1), .enT3(enT3), .enT4(enT4),
      .start(start), .ird(ird), .ccr(ccr), .dbCount(dbCount),
      .busy(busy), .done(done), .condTrue(condTrue), .takeBranch(takeBranch),
      .sccByte(sccByte), .newCount(newCount), .cntWr(cntWr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: condition table, class and results from the opcode fields
   function automatic exp_t model(input logic [15:0] ir, input logic [4:0] f, input logic [15:0] cnt);
      exp_t e;
      int op, cc, sz, mode;
      logic n, z, v, c;
      logic [15:0] t;
      bit is_bcc, is_scc, is_dbcc;
      op = int'(ir[15:12]); cc = int'(ir[11:8]); sz = int'(ir[7:6]); mode = int'(ir[5:3]);
      c = f[0]; v = f[1]; z = f[2]; n = f[3];
      t[0] = 1;        t[1] = 0;
      t[2] = !c && !z; t[3] = c || z;
      t[4] = !c;       t[5] = c;
      t[6] = !z;       t[7] = z;
      t[8] = !v;       t[9] = v;
      t[10] = !n;      t[11] = n;
      t[12] = (n == v);         t[13] = (n != v);
      t[14] = !z && (n == v);   t[15] = z || (n != v);
      is_bcc  = (op == 6);
      is_dbcc = (op == 5) && (sz == 3) && (mode == 1);
      is_scc  = (op == 5) && (sz == 3) && (mode != 1);
      e.ct = t[cc];
      if (is_bcc && cc <= 1) e.ct = 1;
      e.tb = 0; e.scc = 0; e.nc = cnt; e.wr = 0; e.lat = 3;
      if (is_bcc) e.tb = e.ct;
      if (is_scc) e.scc = e.ct ? 8'd255 : 8'd0;
      if (is_dbcc && !e.ct) begin
         e.nc  = 16'((int'(cnt) + 65535) % 65536);
         e.wr  = 1;
         e.tb  = (cnt != 0);
         e.lat = 4;
      end
      return e;
   endfunction

   // One clock: present the current phase (or an idle gap), sample after the edge
   task automatic tick(input logic st, input bit allow_gap, output bit en);
      bit gap;
      gap = allow_gap && ($urandom_range(0, 3) == 0);
      start = st;
      enT1 = !gap && (ph == 0);
      enT3 = !gap && (ph == 2);
      enT4 = !gap && (ph == 3);
      en = enT1 || enT3 || enT4;
      @(posedge clk);
      #1;
      if (!gap) ph = (ph + 1) % 4;
   endtask

   task automatic goto_t3();
      bit en;
      int guard = 0;
      while (ph != 2 && guard < 20) begin
         tick(1'b0, 1'b1, en);
         guard++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ct"},   condTrue, 0);
      check({tag, "_tb"},   takeBranch, 0);
      check({tag, "_scc"},  sccByte, 0);
      check({tag, "_nc"},   newCount, 0);
      check({tag, "_wr"},   cntWr, 0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] ir, input logic [4:0] f,
                         input logic [15:0] cnt, input bit noise);
      exp_t e;
      bit en, seen;
      int n, ticks;
      e = model(ir, f, cnt);
      ird = ir; ccr = f; dbCount = cnt;
      goto_t3();
      tick(1'b1, 1'b0, en);
      check({tag, "_busy_capt"}, busy, 1);
      check({tag, "_done_capt"}, done, 0);
      n = 0; ticks = 0; seen = 0;
      while (!seen && ticks < 100) begin
         if (noise) begin
            ird = 16'($urandom); ccr = 5'($urandom); dbCount = 16'($urandom);
         end
         tick(noise ? 1'($urandom) : 1'b0, 1'b1, en);
         if (en) n++;
         ticks++;
         if (done) seen = 1;
      end
      check({tag, "_done_seen"}, 32'(seen), 1);
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_ct"}, condTrue, e.ct);
      check({tag, "_tb"}, takeBranch, e.tb);
      check({tag, "_scc"}, sccByte, e.scc);
      check({tag, "_nc"}, newCount, e.nc);
      check({tag, "_wr"}, cntWr, e.wr);
      tick(1'b0, 1'b1, en);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_hold_tb"}, takeBranch, e.tb);
      check({tag, "_hold_nc"}, newCount, e.nc);
   endtask

   initial begin
      bit en;
      int n;
      logic [15:0] ir;
      pwrUp = 1'b1; start = 0; enT1 = 0; enT3 = 0; enT4 = 0;
      ird = '0; ccr = '0; dbCount = '0;
      repeat (3) tick(1'b0, 1'b0, en);
      check_zero("reset");
      pwrUp = 1'b0;
      tick(1'b0, 1'b0, en);

      run_op("beq", 16'h6700, 5'b00100, 16'h1234, 0);
      run_op("bne_f", 16'h6600, 5'b00100, 16'h0000, 0);
      run_op("bsr", 16'h6100, 5'b00000, 16'h0000, 0);
      for (int i = 0; i < 32; i++)
         run_op($sformatf("sgt%0d", i), 16'h5EC0, 5'(i), 16'h0000, 0);
      run_op("dbf5", 16'h51C8, 5'b00000, 16'h0005, 0);
      run_op("dbf0", 16'h51C8, 5'b00000, 16'h0000, 0);
      run_op("dbeq", 16'h57C8, 5'b00100, 16'h0003, 0);
      run_op("none", 16'h4E71, 5'b11111, 16'hBEEF, 0);

      // Reset asserted while decrementing: everything clears at once
      ird = 16'h51C8; ccr = '0; dbCount = 16'h0005;
      goto_t3();
      tick(1'b1, 1'b0, en);
      n = 0;
      for (int k = 0; k < 40 && n < 2; k++) begin
         tick(1'b0, 1'b1, en);
         if (en) n++;
      end
      #2 pwrUp = 1'b1;
      #1 check_zero("rst_dec");
      for (int k = 0; k < 6; k++) begin
         tick(1'b0, 1'b1, en);
         check($sformatf("rst_hold_done%0d", k), done, 0);
      end
      pwrUp = 1'b0;
      run_op("bra_after_rst", 16'h6000, 5'b00000, 16'h0000, 0);

      run_op("beq_noise", 16'h6700, 5'b00100, 16'h0000, 1);
      run_op("dbf_noise", 16'h51C8, 5'b00000, 16'h0009, 1);

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: ir = 16'h6000 | 16'($urandom_range(0, 15) << 8) | 16'($urandom_range(0, 255));
            1: ir = 16'h50C8 | 16'($urandom_range(0, 15) << 8) | 16'($urandom_range(0, 7));
            2: ir = 16'h50C0 | 16'($urandom_range(0, 15) << 8) | 16'($urandom_range(0, 63));
            default: ir = 16'($urandom);
         endcase
         run_op($sformatf("rnd%0d", i), ir, 5'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ccr_cond_eval.md
CCR_COND_EVAL -- requirements
Module: ccr_cond_eval

Interface
REQ-001 clk  in  1  system clock; all state updates on posedge clk.
REQ-002 pwrUp  in  1  reset, asynchronous, active-high.
REQ-003 enT1, enT3, enT4  in  1 each  microcycle phase enables, one-hot per clk; the block acts only on these.
REQ-004 start  in  1  request, sampled on enT3 while idle.
REQ-005 ird  in  16  instruction register.
REQ-006 ccr  in  5  condition codes {X,N,Z,V,C}; bit0=C, 1=V, 2=Z, 3=N, 4=X.
REQ-007 dbCount  in  16  low word of Dn for DBcc, sampled with start.
REQ-008 busy  out  1  evaluation in progress.
REQ-009 done  out  1  one-clk pulse; results valid from this clk until the next accepted start.
REQ-010 condTrue  out  1  evaluated condition.
REQ-011 takeBranch  out  1  branch/loop redirect decision.
REQ-012 sccByte  out  8  Scc store value.
REQ-013 newCount  out  16  DBcc write-back value.
REQ-014 cntWr  out  1  newCount must be written to Dn.

Function
REQ-015 Class decode, fixed at capture: ird[15:12]=6 -> BCC; ird[15:12]=5 & ird[7:6]=11 & ird[5:3]=001 -> DBCC; ird[15:12]=5 & ird[7:6]=11, other ird[5:3] -> SCC; anything else -> NONE.
REQ-016 cc = ird[11:8]. Truth: 0 T=1, 1 F=0, 2 HI=~C&~Z, 3 LS=C|Z, 4 CC=~C, 5 CS=C, 6 NE=~Z, 7 EQ=Z, 8 VC=~V, 9 VS=V, 10 PL=~N, 11 MI=N, 12 GE=N~^V, 13 LT=N^V, 14 GT=~Z&(N~^V), 15 LE=Z|(N^V).
REQ-017 For BCC, cc=0 (BRA) and cc=1 (BSR) both give condTrue=1.
REQ-018 States: IDLE, CAPT, EVAL, DEC, DONE.
REQ-019 IDLE: on enT3 & start, latch ird, ccr and dbCount; go to CAPT; busy=1 from the next clk.
REQ-020 CAPT: on enT4, compute condTrue from the latched values; go to EVAL.
REQ-021 EVAL: on enT1, branch on class.
  - DBCC with condTrue=0 -> DEC.
  - All other cases -> DONE.
  - Outputs set at this transition:
    - BCC: takeBranch=condTrue.
    - SCC: sccByte = condTrue ? FF : 00.
    - NONE: takeBranch=0, sccByte=00.
    - DBCC with condTrue=1: takeBranch=0, cntWr=0.
REQ-022 DEC: on enT3, newCount = count - 1 mod 2^16 and cntWr=1; takeBranch=1 unless the result is FFFF (then 0); go to DONE.
REQ-023 DONE: for exactly one clk: done=1, busy=0; then IDLE.
REQ-024 start outside IDLE is ignored; ccr and ird changes after capture do not affect results.
REQ-025 start high on the same enT3 that DEC consumes is ignored (not in IDLE).
REQ-026 Latency: done occurs 4 phase-enables after capture for DBCC-false, 3 otherwise.
REQ-027 newCount holds the latched dbCount when cntWr=0.

Reset
REQ-028 pwrUp asserted at any time, including mid-operation: state=IDLE and all outputs 0 immediately (busy, done, condTrue, takeBranch, cntWr = 0; sccByte = 00; newCount = 0000).
REQ-029 After pwrUp deasserts, the first enT3 & start is accepted normally, with no stale done.

Verification
REQ-030 BEQ: ird=0x6700, ccr Z=1 -> condTrue=1, takeBranch=1, done after 3 phases, cntWr=0.
REQ-031 SGT (ird=0x5EC0) over all 32 ccr values -> sccByte=FF exactly when Z=0 and N=V, else 00.
REQ-032 DBF (ird=0x51C8):
  - dbCount=0005 -> newCount=0004, cntWr=1, takeBranch=1.
  - dbCount=0000 -> newCount=FFFF, takeBranch=0 (expired).
REQ-033 DBEQ with Z=1, dbCount=0003 -> cntWr=0, takeBranch=0, newCount=0003.
REQ-034 pwrUp pulsed in DEC -> all outputs 0 at once, no done pulse; a following BRA start completes with takeBranch=1.
REQ-035 ccr toggled and start re-asserted while busy -> results match the captured values, and only one done pulse.
